// File: rtl/timer.sv
// rtl/timer.sv - programmable down-counting timer with CTRL/PRESET/COUNT registers and masked IRQ.
// Optional prescaler on CTRL[7:4] is compiled in when TIMER_PRESCALE_EN is defined.
module timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;

  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_q, irq_d;

`ifdef TIMER_PRESCALE_EN
  logic [3:0]  psc_q, psc_d;
  logic [3:0]  pcnt_q, pcnt_d;
`endif

  logic        wr_ctrl;
  logic        wr_preset;
  logic        tick;
  logic        count_zero;

  // FSM output controls
  logic        do_load;
  logic        do_count;
  logic        do_irq;
  logic        do_clr_en;

  assign wr_ctrl    = WE && (Addr == 2'd0);
  assign wr_preset  = WE && (Addr == 2'd1);
  assign count_zero = (count_q == 32'd0);

`ifdef TIMER_PRESCALE_EN
  assign tick = (pcnt_q == psc_q);
`else
  assign tick = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one transition per clock
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (en_q) state_d = S_LOAD;
      S_LOAD: state_d = S_CNT;
      S_CNT: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (count_zero) begin
          state_d = S_INT;
        end
      end
      S_INT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: load, count-enable, irq set and one-shot enable clear
  always_comb begin
    do_load   = 1'b0;
    do_count  = 1'b0;
    do_irq    = 1'b0;
    do_clr_en = 1'b0;
    case (state_q)
      S_LOAD: do_load = 1'b1;
      S_CNT:  do_count = en_q && !count_zero;
      S_INT: begin
        do_irq    = 1'b1;
        do_clr_en = (mode_q != 2'd1);
      end
      default: ;
    endcase
  end

  // Register next-state: a CTRL write overrides the INT-state enable clear
  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    irq_d    = irq_q;
`ifdef TIMER_PRESCALE_EN
    psc_d    = psc_q;
    pcnt_d   = pcnt_q;
`endif

    if (do_clr_en) en_d = 1'b0;
    if (wr_ctrl) begin
      en_d   = Din[0];
      mode_d = Din[2:1];
      im_d   = Din[3];
`ifdef TIMER_PRESCALE_EN
      psc_d  = Din[7:4];
`endif
    end
    if (wr_preset) preset_d = Din;

    // PRESET only reaches COUNT through LOAD; decrement only on a tick
    if (do_load) begin
      count_d = preset_q;
    end else if (do_count && tick) begin
      count_d = count_q - 32'd1;
    end

`ifdef TIMER_PRESCALE_EN
    // Prescaler restarts on LOAD and holds whenever counting is paused
    if (do_load) begin
      pcnt_d = 4'd0;
    end else if (do_count) begin
      pcnt_d = tick ? 4'd0 : pcnt_q + 4'd1;
    end
`endif

    // Auto-reload pulses for one cycle; other modes hold until CTRL/PRESET write
    if (do_irq) begin
      irq_d = 1'b1;
    end else if (mode_q == 2'd1) begin
      irq_d = 1'b0;
    end else if (wr_ctrl || wr_preset) begin
      irq_d = 1'b0;
    end
  end

  // Register update with reset overriding any bus write
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      irq_q    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      psc_q    <= 4'd0;
      pcnt_q   <= 4'd0;
`endif
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
`ifdef TIMER_PRESCALE_EN
      psc_q    <= psc_d;
      pcnt_q   <= pcnt_d;
`endif
    end
  end

  // Combinational register read
  always_comb begin
    Dout = 32'd0;
    case (Addr)
`ifdef TIMER_PRESCALE_EN
      2'd0: Dout = {24'd0, psc_q, im_q, mode_q, en_q};
`else
      2'd0: Dout = {28'd0, im_q, mode_q, en_q};
`endif
      2'd1: Dout = preset_q;
      2'd2: Dout = count_q;
      default: Dout = 32'd0;
    endcase
  end

  assign IRQ = irq_q & im_q;

endmodule

// File: tb/tb_timer.sv
// tb/tb_timer.sv - directed scoreboard testbench for timer.
module tb_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  timer dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
    Addr = 2'd2;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = a;
    #1;
    v = Dout;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty, observed=%0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] e);
    logic [31:0] v;
    exp_q.push_back(e);
    rd(a, v);
    chk(tag, v);
  endtask

  task automatic chk_irq(input string tag, input logic e);
    exp_q.push_back({31'd0, e});
    #1;
    chk(tag, {31'd0, IRQ});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    WE    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_count(input logic [31:0] target, input string tag);
    logic [31:0] v;
    bit found;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      rd(2'd2, v);
      if (v == target) begin
        found = 1;
        break;
      end
      tick();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for COUNT=%0d, observed=%0h", tag, target, v);
    end
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    WE     = 1'b0;
    Addr   = 2'd0;
    Din    = 32'd0;
    tick();
    do_reset();

    // Reset state and ignored writes
    chk_reg("rst_ctrl", 2'd0, 32'd0);
    chk_reg("rst_preset", 2'd1, 32'd0);
    chk_reg("rst_count", 2'd2, 32'd0);
    chk_irq("rst_irq", 1'b0);
    wr(2'd2, 32'h55);
    wr(2'd3, 32'hAA);
    chk_reg("count_ro", 2'd2, 32'd0);
    chk_reg("addr3_zero", 2'd3, 32'd0);
    chk_reg("ctrl_upper_zero", 2'd0, 32'd0);

    // One-shot: PRESET=5, CTRL=0x9
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);                 // edge E0
    tick();                           // E0+1
    chk_reg("os_count_e1", 2'd2, 32'd0);
    tick();                           // E0+2
    chk_reg("os_count_load", 2'd2, 32'd5);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_reg($sformatf("os_count_dec%0d", i), 2'd2, 32'(5 - i));
    end
    tick();                           // E0+8
    chk_irq("os_irq_e8", 1'b0);
    tick();                           // E0+9
    chk_irq("os_irq_e9", 1'b1);
    chk_reg("os_ctrl_cleared", 2'd0, 32'h8);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_irq("os_irq_hold", 1'b1);
    end
    wr(2'd0, 32'h0);
    chk_irq("os_irq_clear", 1'b0);

    // Auto-reload: PRESET=3, CTRL=0xB, period 7 over 5 periods
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);                 // edge E0
    for (int k = 1; k <= 35; k++) exp_q.push_back({31'd0, (k % 7) == 0});
    for (int k = 1; k <= 35; k++) begin
      tick();
      #1;
      chk($sformatf("ar_irq_k%0d", k), {31'd0, IRQ});
    end

    // Auto-reload with IM=0: no IRQ
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h3);
    for (int k = 1; k <= 35; k++) exp_q.push_back(32'd0);
    for (int k = 1; k <= 35; k++) begin
      tick();
      #1;
      chk("ar_masked", {31'd0, IRQ});
    end

    // Pause/resume: PRESET=10, freeze at 6, re-enable reloads
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    wait_count(32'd7, "pause_wait");
    wr(2'd0, 32'h0);                 // COUNT steps 7->6 on this edge
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_reg("pause_hold", 2'd2, 32'd6);
    end
    wr(2'd0, 32'h1);                 // edge R0
    tick();                           // R0+1
    chk_reg("resume_r1", 2'd2, 32'd6);
    tick();                           // R0+2
    chk_reg("resume_reload", 2'd2, 32'd10);

    // Reset mid-count with a concurrent CTRL write
    do_reset();
    wr(2'd1, 32'd6);
    wr(2'd0, 32'hB);
    wait_count(32'd4, "rst_mid_wait");
    Addr  = 2'd0;
    Din   = 32'hB;
    WE    = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    WE    = 1'b0;
    chk_reg("midrst_ctrl", 2'd0, 32'd0);
    chk_reg("midrst_preset", 2'd1, 32'd0);
    chk_reg("midrst_count", 2'd2, 32'd0);
    chk_irq("midrst_irq", 1'b0);
    for (int k = 0; k < 30; k++) exp_q.push_back(32'd0);
    for (int k = 0; k < 30; k++) begin
      tick();
      #1;
      chk("midrst_no_pulse", {31'd0, IRQ});
    end

    // Prescale field: PRESET=2, CTRL=0x29
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h29);                // edge E0
`ifdef TIMER_PRESCALE_EN
    chk_reg("psc_ctrl", 2'd0, 32'h29);
    lat = 10;
`else
    chk_reg("psc_ctrl", 2'd0, 32'h9);
    lat = 6;
`endif
    for (int k = 1; k <= lat + 2; k++) exp_q.push_back({31'd0, k >= lat});
    for (int k = 1; k <= lat + 2; k++) begin
      tick();
      #1;
      chk($sformatf("psc_irq_k%0d", k), {31'd0, IRQ});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
